// File: rtl/day3_pkg.sv
// rtl/day3_pkg.sv - shared constants, header slices and state encoding for the Day 3 frame sequencer
package day3_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hAA;
  localparam int DEF_SUM_W = 64;
  localparam int DEF_CNT_W = 12;

  // Header word is {lines, k}, big-endian across the HDR_HI and HDR_LO bytes.
  localparam int HDR_LINES_MSB = 15;
  localparam int HDR_LINES_LSB = 4;
  localparam int HDR_K_MSB = 3;
  localparam int HDR_K_LSB = 0;

  typedef enum logic [3:0] {
    IDLE,
    HDR_LEN,
    HDR_HI,
    HDR_LO,
    LINE_START,
    DIGITS,
    WAIT_RES,
    ACCUM,
    SEND
  } state_t;

  function automatic logic bcd_byte_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/day3_tx_serializer.sv
// rtl/day3_tx_serializer.sv - loads a SUM_W-bit word and emits it MSB byte first over valid/ready
module day3_tx_serializer
  import day3_pkg::*;
#(
  parameter int SUM_W = DEF_SUM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SUM_W-1:0] data,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
  output logic             done
);

  localparam int NB = SUM_W / 8;
  localparam int CW = $clog2(NB + 1);

  logic [SUM_W-1:0] sh;
  logic [CW-1:0]    cnt;

  assign tx_data = sh[SUM_W-1 -: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh       <= '0;
      cnt      <= '0;
      tx_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        sh       <= data;
        cnt      <= CW'(NB);
        tx_valid <= 1'b1;
      end else if (tx_valid && tx_ready) begin
        sh  <= sh << 8;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          tx_valid <= 1'b0;
          done     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/day3_frame_ctrl.sv
// rtl/day3_frame_ctrl.sv - frame header parser, BCD digit unpacker and line-result accumulator
// Optional error checking (rx_err, non-BCD nibble, overrun) with DAY3_CTRL_ERRCHK_EN.
module day3_frame_ctrl
  import day3_pkg::*;
#(
  parameter int SUM_W = DEF_SUM_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             rx_err,
  output logic             line_start,
  output logic [3:0]       k_sel,
  output logic             dig_valid,
  output logic [3:0]       dig_data,
  output logic             dig_last,
  input  logic             dig_ready,
  input  logic             line_done,
  input  logic [SUM_W-1:0] line_val,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
  output logic             busy,
  output logic             err
);

  state_t           state;
  logic [7:0]       len;
  logic [7:0]       hdr_hi;
  logic [CNT_W-1:0] lines_left;
  logic [SUM_W-1:0] sum;
  logic [7:0]       hold;
  logic             hold_full;
  logic             nib_lo;
  logic [7:0]       byte_cnt;

  logic [15:0]      hdr_word;
  logic [CNT_W-1:0] hdr_lines;
  logic             hdr_empty;
  logic             dig_hs;
  logic             byte_done;
  logic             hold_free;
  logic             payload_st;
  logic             take_rx;
  logic             from_hold;
  logic             from_rx;
  logic             start_byte;
  logic [3:0]       next_hi;
  logic             ser_load;
  logic             ser_done;
  logic             fault;

  assign hdr_word   = {hdr_hi, rx_data};
  assign hdr_lines  = CNT_W'(hdr_word[HDR_LINES_MSB:HDR_LINES_LSB]);
  assign hdr_empty  = (len == 8'd0) || (hdr_lines == '0);
  assign dig_hs     = dig_valid && dig_ready;
  assign byte_done  = (state == DIGITS) && dig_hs && nib_lo;
  assign hold_free  = !hold_full || byte_done;
  assign payload_st = (state == LINE_START) || (state == DIGITS) ||
                      (state == WAIT_RES) || (state == ACCUM);
  assign take_rx    = rx_valid && payload_st;

  // A byte starts presentation either from a pre-captured hold or straight off the receiver,
  // including the cycle its predecessor's low nibble is accepted.
  assign from_hold  = (state == DIGITS) && !dig_valid && hold_full;
  assign from_rx    = (state == DIGITS) && rx_valid &&
                      ((!dig_valid && !hold_full) || (byte_done && !dig_last));
  assign start_byte = from_hold || from_rx;
  assign next_hi    = from_hold ? hold[7:4] : rx_data[7:4];

  assign ser_load = !fault &&
                    (((state == ACCUM) && (lines_left == CNT_W'(1))) ||
                     ((state == HDR_LO) && rx_valid && hdr_empty));

  assign busy = (state != IDLE);

`ifdef DAY3_CTRL_ERRCHK_EN
  logic err_q;
  logic overrun;
  logic bad_digit;

  assign overrun   = take_rx && !hold_free;
  assign bad_digit = start_byte && !bcd_byte_ok(from_hold ? hold : rx_data);
  assign fault     = (rx_valid && rx_err && (state != SEND)) || overrun || bad_digit;
  assign err       = err_q;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (fault) begin
      err_q <= 1'b1;
    end else if ((state == IDLE) && rx_valid && (rx_data == SYNC_BYTE)) begin
      err_q <= 1'b0;
    end
  end
`else
  logic unused_rx_err;
  assign unused_rx_err = rx_err;
  assign fault         = 1'b0;
  assign err           = 1'b0;
`endif

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      len        <= '0;
      hdr_hi     <= '0;
      lines_left <= '0;
      sum        <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      nib_lo     <= 1'b0;
      byte_cnt   <= '0;
      line_start <= 1'b0;
      k_sel      <= '0;
      dig_valid  <= 1'b0;
      dig_data   <= '0;
      dig_last   <= 1'b0;
    end else begin
      line_start <= 1'b0;
      if (fault) begin
        state     <= IDLE;
        dig_valid <= 1'b0;
        dig_last  <= 1'b0;
        hold_full <= 1'b0;
        nib_lo    <= 1'b0;
      end else begin
        if (take_rx) begin
          hold      <= rx_data;
          hold_full <= 1'b1;
        end else if (byte_done) begin
          hold_full <= 1'b0;
        end

        case (state)
          IDLE: begin
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
              sum   <= '0;
              state <= HDR_LEN;
            end
          end
          HDR_LEN: begin
            if (rx_valid) begin
              len   <= rx_data;
              state <= HDR_HI;
            end
          end
          HDR_HI: begin
            if (rx_valid) begin
              hdr_hi <= rx_data;
              state  <= HDR_LO;
            end
          end
          HDR_LO: begin
            if (rx_valid) begin
              lines_left <= hdr_lines;
              k_sel      <= hdr_word[HDR_K_MSB:HDR_K_LSB];
              if (hdr_empty) begin
                state <= SEND;
              end else begin
                state      <= LINE_START;
                line_start <= 1'b1;
              end
            end
          end
          LINE_START: begin
            byte_cnt <= '0;
            state    <= DIGITS;
          end
          DIGITS: begin
            if (start_byte) begin
              dig_valid <= 1'b1;
              dig_data  <= next_hi;
              dig_last  <= 1'b0;
              nib_lo    <= 1'b0;
              byte_cnt  <= byte_cnt + 8'd1;
            end else if (dig_hs && !nib_lo) begin
              dig_data <= hold[3:0];
              nib_lo   <= 1'b1;
              dig_last <= (byte_cnt == len);
            end else if (byte_done) begin
              dig_valid <= 1'b0;
              dig_last  <= 1'b0;
              nib_lo    <= 1'b0;
              if (dig_last) state <= WAIT_RES;
            end
          end
          WAIT_RES: begin
            if (line_done) begin
              sum   <= sum + line_val;
              state <= ACCUM;
            end
          end
          ACCUM: begin
            lines_left <= lines_left - CNT_W'(1);
            if (lines_left == CNT_W'(1)) begin
              state <= SEND;
            end else begin
              state      <= LINE_START;
              line_start <= 1'b1;
            end
          end
          SEND: begin
            hold_full <= 1'b0;
            if (ser_done) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  day3_tx_serializer #(
    .SUM_W(SUM_W)
  ) u_tx_ser (
    .clk     (sysclk),
    .rst     (rst),
    .load    (ser_load),
    .data    (sum),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .done    (ser_done)
  );

endmodule

// File: tb/tb_day3_frame_ctrl.sv
// tb/tb_day3_frame_ctrl.sv - table-driven frame vectors plus stall, reset and error sequences
module tb_day3_frame_ctrl;

  logic        sysclk;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_err;
  logic        line_start;
  logic [3:0]  k_sel;
  logic        dig_valid;
  logic [3:0]  dig_data;
  logic        dig_last;
  logic        dig_ready;
  logic        line_done;
  logic [63:0] line_val;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        busy;
  logic        err;

  day3_frame_ctrl dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_err    (rx_err),
    .line_start(line_start),
    .k_sel     (k_sel),
    .dig_valid (dig_valid),
    .dig_data  (dig_data),
    .dig_last  (dig_last),
    .dig_ready (dig_ready),
    .line_done (line_done),
    .line_val  (line_val),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .err       (err)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  typedef struct {
    logic [7:0]       len;
    logic [7:0]       hi;
    logic [7:0]       lo;
    int               pbase;
    logic [4:0][63:0] lv;
    logic [3:0]       exp_k;
    int               exp_starts;
    int               exp_digs;
    int               exp_lasts;
    logic [63:0]      exp_sum;
  } vec_t;

  vec_t        vecs [6];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          n_starts = 0;
  int          n_lasts = 0;
  logic [3:0]  got_dig [$];
  logic [7:0]  got_tx [$];
  logic [63:0] res_arr [32];
  int          res_wr = 0;
  int          res_rd = 0;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e);
    rx_data  = b;
    rx_err   = e;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (busy && c < 5000) begin
      tick(1);
      c++;
    end
    chk({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic chk_tx(input string name, input int base, input logic [63:0] sum);
    int bad;
    bad = 0;
    chk({name, "_tx_count"}, 64'(got_tx.size() - base), 64'd8);
    for (int j = 0; j < 8; j++)
      if (base + j >= got_tx.size() || got_tx[base + j] !== sum[63 - 8*j -: 8]) bad++;
    chk({name, "_tx_bytes"}, 64'(bad), 64'd0);
  endtask

  function automatic logic [7:0] bcd(input int v);
    int m;
    m = v % 100;
    return {4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic vec_t mk(input logic [7:0] len, input logic [7:0] hi, input logic [7:0] lo,
                              input int pbase, input logic [63:0] v0, input logic [63:0] v1,
                              input logic [63:0] v2, input logic [63:0] v3, input logic [63:0] v4,
                              input logic [3:0] k, input int st, input int dg, input int ls,
                              input logic [63:0] sum);
    vec_t v;
    v.len = len; v.hi = hi; v.lo = lo; v.pbase = pbase;
    v.lv[0] = v0; v.lv[1] = v1; v.lv[2] = v2; v.lv[3] = v3; v.lv[4] = v4;
    v.exp_k = k; v.exp_starts = st; v.exp_digs = dg; v.exp_lasts = ls; v.exp_sum = sum;
    return v;
  endfunction

  // Observers sample half a cycle before the edge that completes each handshake.
  always @(negedge sysclk) begin
    if (!rst) begin
      if (line_start) n_starts++;
      if (dig_valid && dig_ready) begin
        got_dig.push_back(dig_data);
        if (dig_last) n_lasts++;
      end
      if (tx_valid && tx_ready) got_tx.push_back(tx_data);
    end
  end

  // Solver stand-in: reports the next queued result a few cycles after the last digit.
  initial begin
    line_done = 1'b0;
    line_val  = '0;
    forever begin
      @(negedge sysclk);
      if (!rst && dig_valid && dig_ready && dig_last) begin
        tick(3);
        line_val  = res_arr[res_rd];
        res_rd++;
        line_done = 1'b1;
        tick(1);
        line_done = 1'b0;
      end
    end
  end

  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge sysclk);
      #1;
      tx_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic run_frame(input int idx);
    vec_t       v;
    int         lines;
    int         b_st;
    int         b_dig;
    int         b_last;
    int         b_tx;
    int         bad;
    logic [7:0] b;
    logic [3:0] exp_dig [$];
    string      nm;
    v      = vecs[idx];
    nm     = $sformatf("vec%0d", idx);
    lines  = int'({v.hi, v.lo[7:4]});
    b_st   = n_starts;
    b_dig  = got_dig.size();
    b_last = n_lasts;
    b_tx   = got_tx.size();
    for (int j = 0; j < ((v.len == 0) ? 0 : lines) && j < 5; j++) begin
      res_arr[res_wr] = v.lv[j];
      res_wr++;
    end
    send_byte(8'h55, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(v.len, 1'b0);
    send_byte(v.hi, 1'b0);
    send_byte(v.lo, 1'b0);
    tick(2);
    chk({nm, "_k_sel"}, 64'(k_sel), 64'(v.exp_k));
    for (int i = 0; i < int'(v.len) * lines; i++) begin
      b = bcd(v.pbase + i);
      exp_dig.push_back(b[7:4]);
      exp_dig.push_back(b[3:0]);
      send_byte(b, 1'b0);
      tick(7);
    end
    wait_idle(nm);
    chk({nm, "_line_starts"}, 64'(n_starts - b_st), 64'(v.exp_starts));
    chk({nm, "_dig_lasts"}, 64'(n_lasts - b_last), 64'(v.exp_lasts));
    chk({nm, "_dig_count"}, 64'(got_dig.size() - b_dig), 64'(v.exp_digs));
    bad = 0;
    for (int i = 0; i < exp_dig.size(); i++)
      if (b_dig + i >= got_dig.size() || got_dig[b_dig + i] !== exp_dig[i]) bad++;
    chk({nm, "_digits"}, 64'(bad), 64'd0);
    chk_tx(nm, b_tx, v.exp_sum);
    chk({nm, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    int         b_dig;
    int         b_last;
    int         b_tx;
    int         bad;
    logic [3:0] stall_exp [8];

    vecs[0] = mk(8'h01, 8'h00, 8'h12, 39, 64'h27, 0, 0, 0, 0, 4'h2, 1, 2, 1, 64'h27);
    vecs[1] = mk(8'h32, 8'h00, 8'h5C, 0, 64'h0000_0100_0000_0000, 64'h0000_0100_0000_0000,
                 64'h0000_0100_0000_0000, 64'h0000_0100_0000_0000, 64'h0000_000C_6D0C_4961,
                 4'hC, 5, 500, 5, 64'h0000_040C_6D0C_4961);
    vecs[2] = mk(8'h05, 8'h00, 8'h0C, 0, 0, 0, 0, 0, 0, 4'hC, 0, 0, 0, 64'h0);
    vecs[3] = mk(8'h02, 8'h00, 8'h23, 50, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                 0, 0, 0, 4'h3, 2, 8, 2, 64'hFFFF_FFFF_FFFF_FFFE);
    vecs[4] = mk(8'h00, 8'h00, 8'h15, 0, 0, 0, 0, 0, 0, 4'h5, 0, 0, 0, 64'h0);
    vecs[5] = mk(8'h03, 8'h00, 8'h31, 7, 64'h1, 64'h2, 64'h3, 0, 0, 4'h1, 3, 18, 3, 64'h6);

    rst       = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    rx_err    = 1'b0;
    dig_ready = 1'b1;
    tick(3);
    chk("reset_outputs", 64'({line_start, k_sel, dig_valid, dig_data, dig_last, tx_valid,
                              tx_data, busy, err}), 64'd0);
    rst = 1'b0;
    tick(2);
    chk("post_reset_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 6; i++) run_frame(i);

    // Solver stalls for 50 cycles with a high nibble on offer.
    stall_exp = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    b_dig  = got_dig.size();
    b_last = n_lasts;
    b_tx   = got_tx.size();
    res_arr[res_wr] = 64'h1234;
    res_wr++;
    send_byte(8'hAA, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    tick(4);
    send_byte(8'h12, 1'b0);
    chk("first_digit_latency", 64'({dig_valid, dig_data}), 64'h11);
    tick(6);
    dig_ready = 1'b0;
    send_byte(8'h34, 1'b0);
    tick(2);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (!(dig_valid && dig_data == 4'd3)) bad++;
      tick(1);
    end
    chk("stall_dig_stable", 64'(bad), 64'd0);
    dig_ready = 1'b1;
    tick(6);
    send_byte(8'h56, 1'b0);
    tick(7);
    send_byte(8'h78, 1'b0);
    tick(7);
    wait_idle("stall");
    chk("stall_dig_count", 64'(got_dig.size() - b_dig), 64'd8);
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (b_dig + i >= got_dig.size() || got_dig[b_dig + i] !== stall_exp[i]) bad++;
    chk("stall_digits", 64'(bad), 64'd0);
    chk("stall_lasts", 64'(n_lasts - b_last), 64'd1);
    chk_tx("stall", b_tx, 64'h1234);

    // Reset in the middle of a line abandons the frame.
    send_byte(8'hAA, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    tick(4);
    send_byte(8'h12, 1'b0);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("midframe_reset", 64'({busy, dig_valid, tx_valid}), 64'd0);

`ifdef DAY3_CTRL_ERRCHK_EN
    b_dig = got_dig.size();
    b_tx  = got_tx.size();
    send_byte(8'hAA, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h12, 1'b0);
    tick(4);
    send_byte(8'h3A, 1'b0);
    tick(3);
    chk("bad_nibble_err", 64'({err, busy, dig_valid}), 64'h4);
    send_byte(8'hAA, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h12, 1'b0);
    tick(4);
    send_byte(8'h39, 1'b1);
    tick(3);
    chk("rx_err_err", 64'({err, busy, dig_valid}), 64'h4);
    tick(20);
    chk("err_no_digits", 64'(got_dig.size() - b_dig), 64'd0);
    chk("err_no_tx", 64'(got_tx.size() - b_tx), 64'd0);
    run_frame(0);
`else
    b_dig = got_dig.size();
    b_tx  = got_tx.size();
    res_arr[res_wr] = 64'h5;
    res_wr++;
    send_byte(8'hAA, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h12, 1'b0);
    tick(4);
    send_byte(8'h3A, 1'b1);
    tick(7);
    wait_idle("passthru");
    chk("passthru_dig_count", 64'(got_dig.size() - b_dig), 64'd2);
    if (got_dig.size() - b_dig == 2)
      chk("passthru_digits", 64'({got_dig[b_dig], got_dig[b_dig + 1]}), 64'h3A);
    chk_tx("passthru", b_tx, 64'h5);
    chk("passthru_err", 64'(err), 64'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/day3_frame_ctrl.md
# day3_frame_ctrl

Frame sequencer for the Day 3 joltage datapath. It sits between the UART receiver and transmitter and the per-line digit-selection solver. It parses the 4-byte frame header, unpacks packed-BCD payload bytes into a digit stream for the solver, and brackets each line with start/last strobes. It accumulates the per-line results into a 64-bit sum and serialises that sum MSB-first to the UART transmitter.

## Interface
Parameters:
- SUM_W, 64, accumulator and line-result width (transmitted as SUM_W/8 bytes)
- CNT_W, 12, line-count field width

Ports:
- sysclk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- rx_valid  in  1  one-cycle pulse: rx_data holds a received byte
- rx_data  in  8  received byte
- rx_err  in  1  parity/framing error flag, qualified by rx_valid
- line_start  out  1  one-cycle pulse: solver clears state for a new line
- k_sel  out  4  digits-to-select count from header, stable for the whole frame
- dig_valid  out  1  digit offered to solver
- dig_data  out  4  digit value
- dig_last  out  1  qualifies the final digit of a line
- dig_ready  in  1  solver accepts digit when dig_valid & dig_ready
- line_done  in  1  one-cycle pulse: line_val valid
- line_val  in  SUM_W  per-line result
- tx_valid  out  1  byte offered to UART transmitter
- tx_data  out  8  byte to transmit
- tx_ready  in  1  transmitter accepts when tx_valid & tx_ready
- busy  out  1  high in any state except IDLE
- err  out  1  sticky error flag, cleared only by rst or a new 0xAA sync in IDLE

## Operation
- Header: 0xAA sync, L = payload bytes per line (2L digits), then {lines[11:0], k[3:0]} big-endian over two bytes. Example: AA 32 00 5C gives L=50, lines=5, k=12.
- States:
  - IDLE: discard bytes other than 0xAA.
  - HDR_LEN, HDR_HI, HDR_LO: capture L, lines and k.
  - LINE_START: one-cycle line_start pulse.
  - DIGITS: unpack payload bytes.
  - WAIT_RES: wait for line_done.
  - ACCUM: add line_val into sum.
  - SEND: transmit the sum.
  - Return to IDLE when SEND completes.
- HDR_LO transitions:
  - If L==0 or lines==0: go straight to SEND with sum=0.
  - Otherwise: go to LINE_START.
- DIGITS:
  - Each payload byte loads a 1-byte hold register.
  - The high nibble is offered first, then the low nibble, each held until the handshake completes.
  - dig_last is asserted with the low nibble of the L-th byte of the line, after which the state moves to WAIT_RES.
- Payload bytes arriving in WAIT_RES, ACCUM or LINE_START are captured into the hold register and offered on entry to DIGITS.
- Overrun: rx_valid while the hold register is still full.
- ACCUM: sum <= sum + line_val, modulo 2^SUM_W. Then decrement the line counter: go to LINE_START if lines remain, else SEND.
- SEND: SUM_W/8 bytes, sum[SUM_W-1 -: 8] first, each held on tx_data until tx_ready.
- Bytes received during SEND or HDR_* are consumed as header or ignored as specified. No frame queueing.
- line_done outside WAIT_RES is ignored.
- Reset mid-frame returns to IDLE. The host must re-send a complete frame.

## Timing
- Reset values: all outputs 0, state IDLE, sum 0, counters 0, hold register empty.
- rx_valid in DIGITS with empty hold register: dig_valid=1 with the high nibble on the next cycle.
- After a high-nibble handshake: the low nibble is presented on the following cycle.
- line_start is asserted exactly one cycle. The first dig_valid of a line is no earlier than the cycle after line_start.
- line_done to updated sum: 1 cycle (ACCUM). The next line_start follows 1 cycle later.
- Final ACCUM to first tx_valid: 1 cycle. Each tx_valid & tx_ready advances to the next byte on the next cycle; tx_valid stays high between bytes.
- Simultaneous rx_valid and the last-nibble handshake: the byte is accepted, no overrun.

## Configuration
- DAY3_CTRL_ERRCHK_EN defined, an error occurs on any of:
  - rx_err with rx_valid
  - a nibble >9 in DIGITS
  - overrun
- On error: set err, drop dig_valid, return to IDLE. No result is transmitted.
- Without the macro:
  - rx_err and invalid nibbles are ignored (digits are passed through unchanged).
  - On overrun, the new byte overwrites the hold register.
  - err is tied to 0.

## Structure
- day3_pkg holds:
  - SYNC_BYTE=8'hAA
  - the state enum
  - SUM_W and CNT_W defaults
  - the header field-slice constants
- One sub-module: day3_tx_serializer. It loads SUM_W bits and emits bytes MSB-first with a valid/ready handshake. Parsing, unpacking and accumulation stay in the top.

## Test plan
- Frame AA 01 00 12 with payload 0x39, solver model returning 39:
  - k_sel=2.
  - Digits 3 then 9, dig_last on 9.
  - tx bytes 00 00 00 00 00 00 00 27.
- Frame AA 32 00 5C with 250 payload bytes:
  - 5 line_start pulses, 500 digit handshakes, 5 dig_last, k_sel=0xC.
  - Solver model values summing to 0x0000040C6D0C4961 must be transmitted as 00 00 04 0C 6D 0C 49 61.
- dig_ready held low for 50 cycles mid-line: dig_data stable, no digit lost or duplicated.
- Frame AA 05 00 0C (lines=0): immediate 8 zero bytes, no line_start.
- Two line_val of 0xFFFFFFFFFFFFFFFF: sum wraps, transmitted FF FF FF FF FF FF FF FE.
- With DAY3_CTRL_ERRCHK_EN, payload byte 0x3A or rx_err:
  - err=1, return to IDLE, no tx bytes.
  - A following valid frame completes normally with err cleared.
